// File: rtl/rr_resp_arbiter_s2m_if.sv
// R-channel bundle between 3 slave ports and 3 masters, plus arbiter status.
// slave modport is the arbiter's view; master modport is the surrounding fabric's view.
interface rr_resp_arbiter_s2m_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [2:0]          s_rvalid;
  logic [2:0]          s_rready;
  logic [3*DATA_W-1:0] s_rdata;
  logic [3*ID_W-1:0]   s_rid;
  logic [5:0]          s_rresp;
  logic [2:0]          s_rlast;
  logic [2:0]          m_rvalid;
  logic [2:0]          m_rready;
  logic [DATA_W-1:0]   m_rdata;
  logic [ID_W-1:0]     m_rid;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic [2:0]          sel;
  logic                err_drop;

  modport slave (
    input  s_rvalid, s_rdata, s_rid, s_rresp, s_rlast, m_rready,
    output s_rready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast, sel, err_drop
  );

  modport master (
    output s_rvalid, s_rdata, s_rid, s_rresp, s_rlast, m_rready,
    input  s_rready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast, sel, err_drop
  );
endinterface

// File: rtl/rr_resp_arbiter_s2m.sv
// Round-robin R-burst arbiter, 3 slaves -> 3 masters routed by RID top bits; grant locked until RLAST.
// Latency: 1 idle cycle per burst, then 0-cycle pass-through; m_rready low stalls the granted slave.
module rr_resp_arbiter_s2m #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_resp_arbiter_s2m_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_grant, w_grant_nxt;
  logic [2:0]  r_last_winner, w_last_nxt;
  logic [1:0]  r_dest, w_dest_nxt;

  // Slot 3 is a zero pad so 2-bit indices never select outside the arrays.
  logic [DATA_W-1:0] w_data [4];
  logic [ID_W-1:0]   w_rid  [4];
  logic [1:0]        w_resp [4];
  logic [3:0]        w_vld_x, w_last_x, w_m_rdy_x;

  for (genvar k = 0; k < 3; k++) begin : g_unpack
    assign w_data[k] = bus.s_rdata[k*DATA_W +: DATA_W];
    assign w_rid[k]  = bus.s_rid[k*ID_W +: ID_W];
    assign w_resp[k] = bus.s_rresp[2*k +: 2];
  end
  assign w_data[3]  = '0;
  assign w_rid[3]   = '0;
  assign w_resp[3]  = '0;
  assign w_vld_x    = {1'b0, bus.s_rvalid};
  assign w_last_x   = {1'b0, bus.s_rlast};
  assign w_m_rdy_x  = {1'b0, bus.m_rready};

  logic [1:0] w_start, w_win_idx, w_g;
  logic       w_g_vld, w_g_rdy, w_xfer;

  always_comb begin
    case (r_last_winner)
      3'b001:  w_start = 2'd1;
      3'b010:  w_start = 2'd2;
      default: w_start = 2'd0;
    endcase
  end

  // Scan from the far end so the first requester after last_winner wins.
  always_comb begin
    w_win_idx = w_start;
    for (int k = 2; k >= 0; k--) begin
      if (w_vld_x[(int'(w_start) + k) % 3]) w_win_idx = 2'((int'(w_start) + k) % 3);
    end
  end

  assign w_g     = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);
  assign w_g_vld = w_vld_x[w_g];

  logic [2:0]        w_s_rready, w_m_rvalid, w_sel;
  logic [DATA_W-1:0] w_m_rdata;
  logic [ID_W-1:0]   w_m_rid;
  logic [1:0]        w_m_rresp;
  logic              w_m_rlast, w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_winner;
    w_dest_nxt  = r_dest;
    w_s_rready  = '0;
    w_m_rvalid  = '0;
    w_sel       = '0;
    w_m_rdata   = '0;
    w_m_rid     = '0;
    w_m_rresp   = '0;
    w_m_rlast   = 1'b0;
    w_err       = 1'b0;
    w_g_rdy     = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.s_rvalid) begin
          w_grant_nxt = 3'b001 << w_win_idx;
          w_dest_nxt  = w_rid[w_win_idx][ID_W-1 -: 2];
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        w_sel     = r_grant;
        w_m_rdata = w_data[w_g];
        w_m_rid   = w_rid[w_g];
        w_m_rresp = w_resp[w_g];
        w_m_rlast = w_last_x[w_g];
        if (r_dest == 2'd3) begin
          // No master 3: sink the burst so the slave is not wedged.
          w_g_rdy = 1'b1;
          w_err   = w_g_vld;
        end else begin
          w_g_rdy    = w_m_rdy_x[r_dest];
          w_m_rvalid = {2'b00, w_g_vld} << r_dest;
        end
        w_s_rready = {2'b00, w_g_rdy} << w_g;
        w_xfer     = w_g_vld & w_g_rdy;
        if (w_xfer && w_last_x[w_g]) begin
          w_last_nxt  = r_grant;
          w_grant_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_winner <= '0;
      r_dest        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last_winner <= w_last_nxt;
      r_dest        <= w_dest_nxt;
    end
  end

  assign bus.s_rready = w_s_rready;
  assign bus.m_rvalid = w_m_rvalid;
  assign bus.m_rdata  = w_m_rdata;
  assign bus.m_rid    = w_m_rid;
  assign bus.m_rresp  = w_m_rresp;
  assign bus.m_rlast  = w_m_rlast;
  assign bus.sel      = w_sel;
  assign bus.err_drop = w_err;
endmodule
